// File: rtl/lock_pkg.sv
// Shared definitions for the lock subsystem: clock frequency, the keypad
// arbiter's state encodings, the "no key" code and small zero-constant
// helpers used by both the arbiter and the lock state machine.
package lock_pkg;

    localparam int CLOCK_FREQ = 50000000;

    localparam logic [3:0] KEY_NONE = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SESSION = 2'd1,
        ST_HOLD    = 2'd2,
        ST_LOCKOUT = 2'd3
    } arb_state_t;

    function automatic logic is_key_none(input logic [3:0] key);
        return key == KEY_NONE;
    endfunction

    function automatic logic [3:0] zero_key();
        return KEY_NONE;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Up-counting cycle timer shared by every timed arbiter state.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   i_clear        synchronous clear to zero (wins over i_enable)
//   i_enable       count one cycle
//   i_limit        terminal count
//   o_done         high once the count has reached i_limit
// The count stops at the terminal value instead of wrapping.
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    assign o_done = (r_count >= i_limit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_done) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/keypad_session_arbiter.sv
// Shares the lock's single 4-bit key input between keypad A (front panel)
// and keypad B (remote panel). One keypad at a time owns an entry session;
// only its keys are forwarded. A session ends on a lock/unlock event, a lock
// error or an idle timeout, followed by a key-free holdoff. Repeated failures
// trigger a lockout period.
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   keyA, keyB            keypad codes, 0 = no key
//   lockLocked, lockError lock status feedback
//   keyOut                key bus to the lock (registered)
//   grantA, grantB        session owner flags, one-hot or both zero
//   lockout               high while locked out
//   failCount             consecutive failed entries
module keypad_session_arbiter #(
    parameter int CLOCK_FREQ   = lock_pkg::CLOCK_FREQ,
    parameter int IDLE_TIMEOUT = 12 * CLOCK_FREQ,
    parameter int HOLDOFF      = CLOCK_FREQ / 10,
    parameter int MAX_FAILS    = 3,
    parameter int LOCKOUT      = 30 * CLOCK_FREQ
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [3:0]                     keyA,
    input  logic [3:0]                     keyB,
    input  logic                           lockLocked,
    input  logic                           lockError,
    output logic [3:0]                     keyOut,
    output logic                           grantA,
    output logic                           grantB,
    output logic                           lockout,
    output logic [$clog2(MAX_FAILS+1)-1:0] failCount
);

    import lock_pkg::*;

    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int T_MAX   = (IDLE_TIMEOUT > LOCKOUT)
                           ? ((IDLE_TIMEOUT > HOLDOFF) ? IDLE_TIMEOUT : HOLDOFF)
                           : ((LOCKOUT > HOLDOFF) ? LOCKOUT : HOLDOFF);
    localparam int TIMER_W = $clog2(T_MAX + 1);

    arb_state_t        r_state, w_state_nx;
    // Arm flags: set when the keypad read "no key" last cycle. They clear on
    // reset so a key held through reset must be released before it counts.
    logic              r_armA, r_armB;
    logic              r_ptrB;          // 0: A wins a tie, 1: B wins a tie
    logic              r_lockedPrev, r_errPrev;

    logic              w_freshA, w_freshB, w_success, w_failure;
    logic [3:0]        w_ownerKey, w_keyOut_nx;
    logic              w_grantA_nx, w_grantB_nx, w_lockout_nx, w_ptrB_nx;
    logic [FAIL_W-1:0] w_fail_nx, w_fail_inc;
    logic              w_tclr, w_ten, w_tdone;
    logic [TIMER_W-1:0] w_tlimit;

    assign w_freshA   = !is_key_none(keyA) && r_armA;
    assign w_freshB   = !is_key_none(keyB) && r_armB;
    assign w_success  = (lockLocked != r_lockedPrev);
    assign w_failure  = lockError && !r_errPrev;
    assign w_ownerKey = grantA ? keyA : keyB;
    assign w_fail_inc = (failCount == FAIL_W'(MAX_FAILS)) ? failCount
                                                          : failCount + FAIL_W'(1);

    // The timer counts from zero after every state entry; each timed state
    // ends when the count reaches its duration minus one, so the state lasts
    // exactly the nominal number of cycles.
    always_comb begin
        w_tlimit = '0;
        case (r_state)
            ST_SESSION: w_tlimit = TIMER_W'(IDLE_TIMEOUT - 1);
            ST_HOLD:    w_tlimit = TIMER_W'(HOLDOFF - 1);
            ST_LOCKOUT: w_tlimit = TIMER_W'(LOCKOUT - 1);
            default:    w_tlimit = '0;
        endcase
    end

    cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_tclr),
        .i_enable (w_ten),
        .i_limit  (w_tlimit),
        .o_done   (w_tdone)
    );

    always_comb begin
        w_state_nx   = r_state;
        w_keyOut_nx  = zero_key();
        w_grantA_nx  = grantA;
        w_grantB_nx  = grantB;
        w_lockout_nx = 1'b0;
        w_fail_nx    = failCount;
        w_ptrB_nx    = r_ptrB;
        w_tclr       = 1'b0;
        w_ten        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_grantA_nx = 1'b0;
                w_grantB_nx = 1'b0;
                if (w_freshA && (!w_freshB || !r_ptrB)) begin
                    w_state_nx  = ST_SESSION;
                    w_grantA_nx = 1'b1;
                    w_keyOut_nx = keyA;
                    w_tclr      = 1'b1;
                end else if (w_freshB) begin
                    w_state_nx  = ST_SESSION;
                    w_grantB_nx = 1'b1;
                    w_keyOut_nx = keyB;
                    w_tclr      = 1'b1;
                end
            end
            ST_SESSION: begin
                // Success is checked first so it wins over a simultaneous error.
                if (w_success || w_failure || (is_key_none(w_ownerKey) && w_tdone)) begin
                    w_grantA_nx = 1'b0;
                    w_grantB_nx = 1'b0;
                    w_ptrB_nx   = !r_ptrB;
                    w_tclr      = 1'b1;
                    w_state_nx  = ST_HOLD;
                    if (w_success) begin
                        w_fail_nx = '0;
                    end else if (w_failure) begin
                        w_fail_nx = w_fail_inc;
                        if (w_fail_inc == FAIL_W'(MAX_FAILS)) begin
                            w_state_nx   = ST_LOCKOUT;
                            w_lockout_nx = 1'b1;
                        end
                    end
                end else begin
                    w_keyOut_nx = w_ownerKey;
                    if (is_key_none(w_ownerKey)) begin
                        w_ten = 1'b1;
                    end else begin
                        w_tclr = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                w_grantA_nx = 1'b0;
                w_grantB_nx = 1'b0;
                if (w_tdone) begin
                    w_state_nx = ST_IDLE;
                    w_tclr     = 1'b1;
                end else begin
                    w_ten = 1'b1;
                end
            end
            ST_LOCKOUT: begin
                w_grantA_nx = 1'b0;
                w_grantB_nx = 1'b0;
                if (w_tdone) begin
                    w_state_nx = ST_IDLE;
                    w_fail_nx  = '0;
                    w_tclr     = 1'b1;
                end else begin
                    w_lockout_nx = 1'b1;
                    w_ten        = 1'b1;
                end
            end
            default: begin
                w_state_nx  = ST_IDLE;
                w_grantA_nx = 1'b0;
                w_grantB_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_armA       <= 1'b0;
            r_armB       <= 1'b0;
            r_ptrB       <= 1'b0;
            r_lockedPrev <= 1'b0;
            r_errPrev    <= 1'b0;
            keyOut       <= KEY_NONE;
            grantA       <= 1'b0;
            grantB       <= 1'b0;
            lockout      <= 1'b0;
            failCount    <= '0;
        end else begin
            r_state      <= w_state_nx;
            // Edge tracking runs in every state so keys pressed during
            // holdoff or lockout have to be re-pressed afterwards.
            r_armA       <= is_key_none(keyA);
            r_armB       <= is_key_none(keyB);
            r_ptrB       <= w_ptrB_nx;
            r_lockedPrev <= lockLocked;
            r_errPrev    <= lockError;
            keyOut       <= w_keyOut_nx;
            grantA       <= w_grantA_nx;
            grantB       <= w_grantB_nx;
            lockout      <= w_lockout_nx;
            failCount    <= w_fail_nx;
        end
    end

endmodule

// File: doc/keypad_session_arbiter.md
# keypad_session_arbiter

- Shares the lock state machine's single 4-bit `key` input between two keypads, A (front panel) and B (remote panel).
- Grants one keypad an exclusive entry session and forwards only that keypad's keys to the lock.
- Ends the session on a lock/unlock event, an error, or an idle timeout.
- Enforces a lockout period after repeated failed entries; sits between the keypad conditioners and the lock.

## Interface
- `CLOCK_FREQ`, 50000000: clock frequency in Hz.
- `IDLE_TIMEOUT`, 12*CLOCK_FREQ: cycles without an owner key press before the session is force-released. Longer than the lock's own 10 s timeout.
- `HOLDOFF`, CLOCK_FREQ/10: cycles `keyOut` is held at zero between sessions.
- `MAX_FAILS`, 3: consecutive failures that trigger lockout.
- `LOCKOUT`, 30*CLOCK_FREQ: lockout duration in cycles.
- `clock`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high; clock `clock`.
- `keyA`  in  4  keypad A code; 0 = no key.
- `keyB`  in  4  keypad B code; 0 = no key.
- `lockLocked`  in  1  lock's `locked` output.
- `lockError`  in  1  lock's `error` output.
- `keyOut`  out  4  key bus driven to the lock.
- `grantA`, `grantB`  out  1 each  session owner flags; one-hot or both zero.
- `lockout`  out  1  high during lockout.
- `failCount`  out  $clog2(MAX_FAILS+1)  consecutive failure count.

## Operation
- States: IDLE, SESSION, HOLD, LOCKOUT. On reset: IDLE; all outputs 0; priority pointer = A; edge-detect registers load 0.
- Fresh press: key != 0 this cycle and == 0 the previous cycle, tracked per keypad.
- IDLE, fresh press on one keypad: grant it, go to SESSION, `keyOut <= that key`.
- IDLE, fresh presses on both keypads in the same cycle: the priority pointer's keypad wins. The pointer flips to the other keypad on every session end.
- SESSION:
  - `keyOut <= owner key` every cycle; the non-owner keypad is ignored.
  - Idle counter resets on any nonzero owner key.
  - Idle counter reaching IDLE_TIMEOUT: go to HOLD; `failCount` unchanged.
- Success: `lockLocked` differs from its registered copy. `failCount <= 0`, go to HOLD.
- Failure: rising edge of `lockError`. `failCount + 1`; go to LOCKOUT if the new count == MAX_FAILS, else HOLD.
- Success and failure in the same cycle: success wins.
- `lockError` rising outside SESSION is ignored; so is a `lockLocked` change.
- HOLD: grants 0, `keyOut` 0 for HOLDOFF cycles, then IDLE. Presses during HOLD are discarded and must be re-pressed (fresh-press rule).
- LOCKOUT: `lockout` 1, grants 0, `keyOut` 0 for LOCKOUT cycles. Then `failCount <= 0`, `lockout <= 0`, go to IDLE.
- Counters saturate at their terminal value and never wrap. All counters clear on entry to each state.

## Timing
- All outputs are registered.
- Latency keypad → `keyOut`: 1 cycle, in SESSION and on the grant edge.
- Grant asserts on the same edge as the first forwarded key.
- The session-ending event is sampled at edge N; `keyOut` = 0 and grants = 0 from edge N+1.
- A key still held by the owner at session end is cut off. The lock sees a release, and its `ready` logic re-arms.
- Async reset mid-session drops the grant and `keyOut` immediately. The lock is reset separately.

## Structure
- Shared package `lock_pkg`:
  - `CLOCK_FREQ`.
  - Arbiter state encodings.
  - `KEY_NONE` = 4'h0.
  - Zero-constant helpers shared with the lock state machine.
- Sub-module `cycle_timer`: load/clear, enable, terminal-count flag, parameterised width. Instanced once; reloaded per state for the idle, holdoff and lockout durations.
- Edge detectors, priority pointer and fail counter are in the top level.

## Test plan
Bench parameters: IDLE_TIMEOUT=20, HOLDOFF=4, LOCKOUT=50, MAX_FAILS=3.

1. `keyA`=8 for 1 cycle, keys 1,4,8, then toggle `lockLocked` → `grantA`=1 on the same edge `keyOut`=8; each key echoed after 1 cycle; HOLD for 4 cycles; `failCount`=0.
2. Fresh presses `keyA`=2 and `keyB`=5 in the same cycle, after reset → A granted, `keyOut`=2, B ignored. Repeat after release → B granted, `keyOut`=5.
3. `lockError` pulsed in 3 successive sessions → `failCount` 1,2,3. `lockout`=1 for 50 cycles with `keyOut`=0 and presses ignored; then `failCount`=0, IDLE.
4. Grant A, then no keys for 20 cycles → release to HOLD; `failCount` unchanged; `keyOut`=0.
5. `lockLocked` toggle and `lockError` rise in the same cycle → treated as success; `failCount`=0.
6. Assert `reset` mid-session while `keyA`=3 is held → grants, `keyOut`, `lockout`, `failCount` = 0 at once. Held `keyA` not re-granted until released and re-pressed.
